// File: rtl/comma_align_ctrl.sv
// K28.5 word-alignment controller for the 10-bit DDR receive deserializer.
// Hunts for commas, requests bit-slips until they land on word boundaries, then tracks lock.
module comma_align_ctrl #(
    parameter int SLIP_PULSE_CYCLES = 4,
    parameter int SETTLE_WORDS      = 4,
    parameter int HUNT_WORDS        = 32,
    parameter int LOCK_COMMAS       = 3,
    parameter int LOSS_COMMAS       = 4
) (
    input  logic       clk_byte,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic       bitslip,
    output logic       locked,
    output logic       lock_lost,
    output logic [3:0] slip_count,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HUNT   = 3'd1;
    localparam logic [2:0] S_SLIP   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_LOCKED = 3'd5;

    localparam int PCW = $clog2(SLIP_PULSE_CYCLES + 1);
    localparam int SCW = $clog2(SETTLE_WORDS + 1);
    localparam int WCW = $clog2(HUNT_WORDS + 1);
    localparam int CCW = $clog2(LOCK_COMMAS + 1);
    localparam int LCW = $clog2(LOSS_COMMAS + 1);

    function automatic logic is_comma(input logic [9:0] x);
        return (x == 10'h0FA) || (x == 10'h305);
    endfunction

    logic [2:0]     state_q, state_d;
    logic [8:0]     prev_q, prev_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [CCW-1:0] comma_cnt_q, comma_cnt_d;
    logic [LCW-1:0] loss_cnt_q, loss_cnt_d;
    logic [SCW-1:0] settle_cnt_q, settle_cnt_d;
    logic [PCW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic           bitslip_q, bitslip_d;
    logic           locked_q, locked_d;
    logic           lock_lost_q, lock_lost_d;
    logic [3:0]     slip_count_q, slip_count_d;

    // rx_valid is a one-cycle strobe with no back-pressure: a word is consumed on every cycle it is high.
    // Only the low 9 bits of the previous word can take part in a straddling comma at offsets 1..9.
    logic [17:0] window;
    logic        hit_c, aligned_c, misaligned_c;
    logic        enter_hunt, enter_slip;

    always_comb begin
        window = {prev_q, rx_data[9:1]};
        hit_c  = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            hit_c = hit_c | is_comma(window[j +: 10]);
        end
        aligned_c    = rx_valid & is_comma(rx_data);
        misaligned_c = rx_valid & ~is_comma(rx_data) & hit_c;
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        word_cnt_d   = word_cnt_q;
        comma_cnt_d  = comma_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        settle_cnt_d = settle_cnt_q;
        pulse_cnt_d  = pulse_cnt_q;
        bitslip_d    = bitslip_q;
        locked_d     = locked_q;
        lock_lost_d  = 1'b0;
        slip_count_d = slip_count_q;
        enter_hunt   = 1'b0;
        enter_slip   = 1'b0;

        if (state_q == S_IDLE) begin
            prev_d = '0;
        end else if (rx_valid) begin
            prev_d = rx_data[8:0];
        end

        // A slip pulse always runs to completion so the deserializer sees a full request.
        if (state_q == S_SLIP) begin
            if (pulse_cnt_q == PCW'(SLIP_PULSE_CYCLES)) begin
                bitslip_d    = 1'b0;
                settle_cnt_d = '0;
                state_d      = enable ? S_SETTLE : S_IDLE;
            end else begin
                pulse_cnt_d = pulse_cnt_q + PCW'(1);
            end
        end else if (!enable) begin
            state_d     = S_IDLE;
            locked_d    = 1'b0;
            word_cnt_d  = '0;
            comma_cnt_d = '0;
            loss_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: enter_hunt = 1'b1;
                S_HUNT: begin
                    if (aligned_c) begin
                        state_d     = S_CHECK;
                        comma_cnt_d = CCW'(1);
                        word_cnt_d  = '0;
                    end else if (misaligned_c) begin
                        enter_slip = 1'b1;
                    end else if (rx_valid) begin
                        if (word_cnt_q == WCW'(HUNT_WORDS - 1)) enter_slip = 1'b1;
                        else word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
                S_SETTLE: begin
                    if (rx_valid) begin
                        if (settle_cnt_q == SCW'(SETTLE_WORDS - 1)) enter_hunt = 1'b1;
                        else settle_cnt_d = settle_cnt_q + SCW'(1);
                    end
                end
                S_CHECK: begin
                    if (aligned_c) begin
                        word_cnt_d = '0;
                        if (comma_cnt_q >= CCW'(LOCK_COMMAS - 1)) begin
                            state_d    = S_LOCKED;
                            locked_d   = 1'b1;
                            loss_cnt_d = '0;
                        end else begin
                            comma_cnt_d = comma_cnt_q + CCW'(1);
                        end
                    end else if (misaligned_c) begin
                        enter_slip = 1'b1;
                    end else if (rx_valid) begin
                        if (word_cnt_q == WCW'(HUNT_WORDS - 1)) enter_hunt = 1'b1;
                        else word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
                S_LOCKED: begin
                    if (aligned_c) begin
                        loss_cnt_d = '0;
                    end else if (misaligned_c) begin
                        if (loss_cnt_q == LCW'(LOSS_COMMAS - 1)) begin
                            enter_hunt  = 1'b1;
                            locked_d    = 1'b0;
                            lock_lost_d = 1'b1;
                        end else begin
                            loss_cnt_d = loss_cnt_q + LCW'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (enter_hunt) begin
            state_d     = S_HUNT;
            word_cnt_d  = '0;
            comma_cnt_d = '0;
            loss_cnt_d  = '0;
        end
        if (enter_slip) begin
            state_d      = S_SLIP;
            bitslip_d    = 1'b1;
            pulse_cnt_d  = PCW'(1);
            word_cnt_d   = '0;
            comma_cnt_d  = '0;
            slip_count_d = (slip_count_q == 4'd9) ? 4'd0 : slip_count_q + 4'd1;
        end
    end

    always_ff @(posedge clk_byte or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            prev_q       <= '0;
            word_cnt_q   <= '0;
            comma_cnt_q  <= '0;
            loss_cnt_q   <= '0;
            settle_cnt_q <= '0;
            pulse_cnt_q  <= '0;
            bitslip_q    <= 1'b0;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
            slip_count_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            word_cnt_q   <= word_cnt_d;
            comma_cnt_q  <= comma_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            bitslip_q    <= bitslip_d;
            locked_q     <= locked_d;
            lock_lost_q  <= lock_lost_d;
            slip_count_q <= slip_count_d;
        end
    end

    assign bitslip    = bitslip_q;
    assign locked     = locked_q;
    assign lock_lost  = lock_lost_q;
    assign slip_count = slip_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_comma_align_ctrl.sv
// Bench for comma_align_ctrl: a bit-stream deserializer model feeds the DUT and a
// word-level reference model predicts every output each cycle.
module tb_comma_align_ctrl;

    localparam int SPC = 4;
    localparam int SW  = 4;
    localparam int HW  = 32;
    localparam int LC  = 3;
    localparam int LOC = 4;

    localparam int ST_IDLE   = 0;
    localparam int ST_HUNT   = 1;
    localparam int ST_SLIP   = 2;
    localparam int ST_SETTLE = 3;
    localparam int ST_CHECK  = 4;
    localparam int ST_LOCKED = 5;

    logic       clk_byte = 1'b0;
    logic       rst_n    = 1'b0;
    logic       enable   = 1'b0;
    logic [9:0] rx_data  = 10'd0;
    logic       rx_valid = 1'b0;
    logic       bitslip, locked, lock_lost;
    logic [3:0] slip_count;
    logic [2:0] state;
    logic [9:0] outs;

    assign outs = {state, bitslip, locked, lock_lost, slip_count};

    comma_align_ctrl #(
        .SLIP_PULSE_CYCLES(SPC), .SETTLE_WORDS(SW), .HUNT_WORDS(HW),
        .LOCK_COMMAS(LC), .LOSS_COMMAS(LOC)
    ) dut (
        .clk_byte  (clk_byte),
        .rst_n     (rst_n),
        .enable    (enable),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .bitslip   (bitslip),
        .locked    (locked),
        .lock_lost (lock_lost),
        .slip_count(slip_count),
        .state     (state)
    );

    // ---------------- clock ----------------
    always #5 clk_byte = ~clk_byte;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        total++;
        if (obs !== expd) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expd, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_state, m_words, m_commas, m_loss, m_pulse_left, m_settle_left, m_slips;
    bit         m_bitslip, m_locked, m_lost;
    logic [9:0] m_prev;

    function automatic bit is_k(input logic [9:0] x);
        return (x == 10'h0FA) || (x == 10'h305);
    endfunction

    function automatic bit mis_k(input logic [9:0] p, input logic [9:0] c);
        int w;
        logic [9:0] s;
        w = int'(p) * 1024 + int'(c);
        for (int k = 1; k <= 9; k++) begin
            s = 10'((w >> k) % 1024);
            if (is_k(s)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE; m_words = 0; m_commas = 0; m_loss = 0;
        m_pulse_left = 0; m_settle_left = 0; m_slips = 0;
        m_bitslip = 0; m_locked = 0; m_lost = 0; m_prev = 10'd0;
    endtask

    task automatic go_hunt();
        m_state = ST_HUNT; m_words = 0; m_commas = 0; m_loss = 0;
    endtask

    task automatic go_slip();
        m_state = ST_SLIP; m_bitslip = 1; m_pulse_left = SPC;
        m_slips = (m_slips + 1) % 10;
    endtask

    task automatic model_step(input bit en, input bit v, input logic [9:0] d);
        bit al, mis;
        int cur;
        cur    = m_state;
        al     = v && is_k(d);
        mis    = v && !al && mis_k(m_prev, d);
        m_lost = 0;
        if (cur == ST_SLIP) begin
            m_pulse_left--;
            if (m_pulse_left == 0) begin
                m_bitslip = 0;
                if (en) begin
                    m_state = ST_SETTLE;
                    m_settle_left = SW;
                end else begin
                    m_state = ST_IDLE;
                end
            end
        end else if (!en) begin
            m_state = ST_IDLE; m_locked = 0;
        end else begin
            case (cur)
                ST_IDLE: go_hunt();
                ST_HUNT: begin
                    if (al) begin
                        m_state = ST_CHECK; m_commas = 1; m_words = 0;
                    end else if (mis) begin
                        go_slip();
                    end else if (v) begin
                        m_words++;
                        if (m_words >= HW) go_slip();
                    end
                end
                ST_SETTLE: begin
                    if (v) begin
                        m_settle_left--;
                        if (m_settle_left == 0) go_hunt();
                    end
                end
                ST_CHECK: begin
                    if (al) begin
                        m_commas++; m_words = 0;
                        if (m_commas >= LC) begin
                            m_state = ST_LOCKED; m_locked = 1; m_loss = 0;
                        end
                    end else if (mis) begin
                        go_slip();
                    end else if (v) begin
                        m_words++;
                        if (m_words >= HW) go_hunt();
                    end
                end
                ST_LOCKED: begin
                    if (al) begin
                        m_loss = 0;
                    end else if (mis) begin
                        m_loss++;
                        if (m_loss >= LOC) begin
                            go_hunt(); m_locked = 0; m_lost = 1;
                        end
                    end
                end
                default: m_state = ST_IDLE;
            endcase
        end
        if (cur == ST_IDLE) m_prev = 10'd0;
        else if (v) m_prev = d;
        exp_q.push_back({3'(m_state), m_bitslip, m_locked, m_lost, 4'(m_slips)});
    endtask

    // ---------------- deserializer / stimulus driver ----------------
    bit         bq[$];
    logic [9:0] raw_q[$];
    int         sym_idx, sym_mode;
    bit         bs_prev, seen_fall, gap_chk;
    int         pw_cur, rises, gap_words, lost_pulses;

    task automatic refill();
        logic [9:0] s;
        if (sym_mode != 1 && sym_idx % 8 == 0)
            s = (sym_mode == 2 && (sym_idx / 8) % 2 == 1) ? 10'h305 : 10'h0FA;
        else
            s = 10'h155;
        sym_idx++;
        for (int b = 9; b >= 0; b--) bq.push_back(s[b]);
    endtask

    task automatic stream_word(output logic [9:0] w);
        while (bq.size() < 10) refill();
        for (int b = 9; b >= 0; b--) w[b] = bq.pop_front();
    endtask

    task automatic slip_bit();
        bit dummy;
        if (bq.size() == 0) refill();
        dummy = bq.pop_front();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; rx_valid = 1'b0; rx_data = 10'd0;
        model_reset();
        exp_q.delete(); exp_q.push_back(10'd0);
        bq.delete(); raw_q.delete(); sym_idx = 0;
        bs_prev = 0; seen_fall = 0; pw_cur = 0; rises = 0; gap_words = 0; lost_pulses = 0;
        repeat (2) @(negedge clk_byte);
        rst_n = 1'b1;
    endtask

    task automatic tick(input bit en);
        logic [9:0] d;
        bit v;
        @(negedge clk_byte);
        if (exp_q.size() == 0) check("sb_empty", 1, 0);
        else check("outs", outs, exp_q.pop_front());
        if (bitslip) pw_cur++;
        if (bitslip && !bs_prev) begin
            rises++;
            if (gap_chk && seen_fall) check("gap_ge_settle", (gap_words >= SW) ? SW : gap_words, SW);
            slip_bit();
        end
        if (!bitslip && bs_prev) begin
            check("pulse_width", pw_cur, SPC);
            pw_cur = 0; seen_fall = 1; gap_words = 0;
        end
        if (lock_lost) lost_pulses++;
        bs_prev = bitslip;
        v = ($urandom_range(0, 3) != 0);
        d = 10'($urandom);
        if (v) begin
            if (raw_q.size() > 0) d = raw_q.pop_front();
            else stream_word(d);
            if (!bitslip) gap_words++;
        end
        enable = en; rx_valid = v; rx_data = d;
        model_step(en, v, d);
    endtask

    // ---------------- test sequence ----------------
    logic [29:0] t3;
    logic [9:0]  w1, w2;

    initial begin
        t3 = {10'h155, 10'h0FA, 10'h155};
        w1 = t3[24:15];
        w2 = t3[14:5];

        // aligned stream
        do_reset();
        check("reset_vals", outs, 10'd0);
        sym_mode = 0; gap_chk = 1;
        for (int i = 0; i < 400 && !m_locked; i++) tick(1);
        tick(1);
        check("al_locked", locked, 1);
        check("al_slip_count", slip_count, 0);
        check("al_no_slips", rises, 0);

        // stream skewed by 3 bits
        do_reset();
        sym_mode = 0;
        repeat (3) slip_bit();
        for (int i = 0; i < 3000 && !m_locked; i++) tick(1);
        tick(1);
        check("off3_locked", locked, 1);
        check("off3_slip_count", slip_count, 7);
        check("off3_rises", rises, 7);

        // no commas at all: blind slips and slip_count wrap
        do_reset();
        sym_mode = 1;
        for (int i = 0; i < 3000 && rises < 11; i++) tick(1);
        check("nc_rises", rises, 11);
        check("nc_wrap", slip_count, 1);

        // loss of lock, with an aligned comma rescuing it first
        do_reset();
        sym_mode = 0;
        for (int i = 0; i < 400 && !m_locked; i++) tick(1);
        sym_mode = 1;
        repeat (3) begin raw_q.push_back(w1); raw_q.push_back(w2); end
        raw_q.push_back(10'h0FA);
        repeat (3) begin raw_q.push_back(w1); raw_q.push_back(w2); end
        for (int i = 0; i < 200 && raw_q.size() > 0; i++) tick(1);
        repeat (3) tick(1);
        check("loss_hold", locked, 1);
        check("loss_no_pulse", lost_pulses, 0);
        raw_q.push_back(w1); raw_q.push_back(w2);
        for (int i = 0; i < 200 && raw_q.size() > 0; i++) tick(1);
        repeat (3) tick(1);
        check("loss_unlocked", locked, 0);
        check("loss_state", state, ST_HUNT);
        check("loss_pulse_cnt", lost_pulses, 1);

        // alternating running disparity commas
        do_reset();
        sym_mode = 2;
        for (int i = 0; i < 400 && !m_locked; i++) tick(1);
        tick(1);
        check("rd_locked", locked, 1);

        // enable dropped in the 2nd pulse cycle, then async reset mid-pulse
        do_reset();
        sym_mode = 1; gap_chk = 0;
        for (int i = 0; i < 300 && !bitslip; i++) tick(1);
        check("ctl_pulse_seen", bitslip, 1);
        repeat (7) tick(0);
        check("ctl_idle", state, ST_IDLE);
        check("ctl_bitslip_low", bitslip, 0);
        for (int i = 0; i < 300 && !bitslip; i++) tick(1);
        tick(1);
        check("arst_pre", bitslip, 1);
        #2 rst_n = 1'b0;
        #1 check("arst_outs", outs, 10'd0);
        do_reset();

        // random enable toggling over a randomly skewed stream
        sym_mode = 0;
        repeat ($urandom_range(0, 9)) slip_bit();
        for (int i = 0; i < 1500; i++) tick($urandom_range(0, 99) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comma_align_ctrl.md
# comma_align_ctrl

Word-alignment controller for the 10-bit DDR receive deserializer. It sits in the `clk_byte` domain directly after the deserializer's `data_parallel`/`valid` outputs and hunts for K28.5 commas. It issues bit-slip requests until commas land on word boundaries, then declares and monitors lock. It replaces the deserializer's valid-count `aligned` indication as the receive path's lock status.

## Interface
Parameters:
- `SLIP_PULSE_CYCLES`, default 4: `clk_byte` cycles that `bitslip` is held high per slip request.
- `SETTLE_WORDS`, default 4: valid words discarded after each slip before evaluation resumes.
- `HUNT_WORDS`, default 32: valid words without any comma before a blind slip or check timeout.
- `LOCK_COMMAS`, default 3: consecutive aligned commas required to enter LOCKED.
- `LOSS_COMMAS`, default 4: consecutive misaligned commas, with no aligned comma between them, that drop lock.

Ports:
- `clk_byte`, in, 1: the single clock. All logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: run alignment. Low forces IDLE.
- `rx_data`, in, 10: word from deserializer `data_parallel`.
- `rx_valid`, in, 1: single-cycle word strobe from deserializer `valid`.
- `bitslip`, out, 1: slip request to the deserializer. Level, held high for `SLIP_PULSE_CYCLES` cycles.
- `locked`, out, 1: word alignment achieved.
- `lock_lost`, out, 1: one-cycle pulse on the LOCKED→HUNT transition.
- `slip_count`, out, 4: mirror of the deserializer slip offset, mod 10.
- `state`, out, 3: encoded FSM state for debug. IDLE=0, HUNT=1, SLIP=2, SETTLE=3, CHECK=4, LOCKED=5.

## Operation
- Comma detection uses only `rx_valid` words. `prev` holds the last valid word, giving a window `w = {prev, rx_data}` of 20 bits.
- COMMA: a 10-bit value equal to 10'h0FA or 10'h305 (K28.5 RD−/RD+).
- Aligned comma: `rx_data` is a COMMA.
- Misaligned comma: `w[k+9:k]` is a COMMA for some k in 1..9, and `rx_data` is not a COMMA.
- IDLE: go to HUNT when `enable` is 1. Clear the word counter, comma counter and `prev`.
- HUNT, on each valid word:
  - aligned comma → CHECK, with comma count = 1;
  - misaligned comma → SLIP;
  - otherwise increment the word counter; reaching `HUNT_WORDS` → SLIP.
- SLIP: drive `bitslip` = 1 for exactly `SLIP_PULSE_CYCLES` cycles. On entry, `slip_count` increments, wrapping 9→0. Then go to SETTLE.
- SETTLE: `bitslip` = 0. Ignore `SETTLE_WORDS` valid words (`prev` is still updated), then go to HUNT with counters cleared.
- CHECK, on each valid word:
  - aligned comma increments the comma count; reaching `LOCK_COMMAS` → LOCKED;
  - misaligned comma → SLIP;
  - `HUNT_WORDS` valid words with no comma → HUNT.
- LOCKED: `locked` = 1.
  - Aligned comma clears the loss counter.
  - Misaligned comma increments it; reaching `LOSS_COMMAS` → HUNT, `lock_lost` pulses, `locked` drops.
  - Non-comma words do not change the loss counter.
- `enable` falling:
  - in SLIP, the pulse completes first, then the FSM goes to IDLE;
  - in any other state, the FSM goes to IDLE on the next edge, with `locked` = 0.
- `slip_count` is not cleared by `enable`, only by reset, because the deserializer offset persists.

## Timing
- Reset values: `bitslip` = 0, `locked` = 0, `lock_lost` = 0, `slip_count` = 0, `state` = IDLE. All internal counters and `prev` are 0.
- All outputs are registered.
- Decision latency: the state change is visible 1 cycle after the deciding `rx_valid` cycle.
- `bitslip` rises 1 cycle after the SLIP decision and falls `SLIP_PULSE_CYCLES` cycles later.
- `bitslip` is never high in two consecutive SLIP visits without at least `SETTLE_WORDS` valid words low between them. This guarantees the deserializer's clk_bit edge detector sees every request.
- `locked` rises on the same edge the state becomes LOCKED, and falls on the same edge the state leaves LOCKED.
- `lock_lost` is high for exactly 1 cycle, coincident with the first HUNT cycle.
- Simultaneous events are resolved as follows:
  - a word that is both aligned and misaligned (overlapping window) counts as aligned;
  - `enable` low takes priority over all word-driven transitions except an in-progress SLIP pulse.
- Counter widths: sized for their parameter values (clog2(max+1)); they saturate and never wrap.
- Reset asserted mid-SLIP drops `bitslip` immediately (async).

## Test plan
- Aligned stream: reset, `enable` = 1, feed 10'h0FA every 8th valid word. Required: 0 slips; `locked` rises 1 cycle after the 3rd comma; `slip_count` = 0.
- Offset 3: feed a comma stream skewed by 3 bits; the bench model rotates on each slip. Required: slips until the window aligns (`slip_count` = 7 at lock); each `bitslip` pulse is 4 cycles wide, separated by ≥4 valid words.
- No comma: feed 32 valid words of 10'h155. Required: `bitslip` asserted after the 32nd; repeats every 32+4 words; `slip_count` wraps 9→0.
- Loss of lock: lock, then feed 4 misaligned commas. Required: `lock_lost` is a 1-cycle pulse, `locked` = 0, state = HUNT. Variant: an aligned comma after 3 misaligned ones keeps lock.
- RD±: alternate 10'h0FA/10'h305 in CHECK. Required: both count; lock after 3.
- Control: deassert `enable` during the 2nd cycle of a SLIP pulse. Required: the pulse completes (4 cycles), then IDLE. Async `rst_n` low mid-pulse: `bitslip` = 0 immediately, all outputs at reset values.
